// File: rtl/serial_comp_sched_if.sv
// serial_comp_sched_if
//  Bundles the requester side, the engine side and the result handshake of
//  the shared serial complementer scheduler.
//  slave  : the scheduler (drives gnt, busy, engine controls, result)
//  master : the environment (requesters, engine, result consumer)
//  Signals:
//   req/req_data      requests and per-requester operands (slice i = [i*W +: W])
//   gnt/busy          one-hot grant pulse, scheduler-busy flag
//   eng_rst_n/eng_load/eng_num/eng_result  engine control and contents
//   res_valid/res_ready/res_data/res_id    result handshake
interface serial_comp_sched_if #(
    parameter int W = 4,
    parameter int N = 4
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]   req;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   gnt;
    logic           busy;
    logic           eng_rst_n;
    logic           eng_load;
    logic [W-1:0]   eng_num;
    logic [W-1:0]   eng_result;
    logic           res_valid;
    logic           res_ready;
    logic [W-1:0]   res_data;
    logic [IW-1:0]  res_id;

    modport slave (
        input  req, req_data, eng_result, res_ready,
        output gnt, busy, eng_rst_n, eng_load, eng_num, res_valid, res_data, res_id
    );

    modport master (
        output req, req_data, eng_result, res_ready,
        input  gnt, busy, eng_rst_n, eng_load, eng_num, res_valid, res_data, res_id
    );
endinterface

// File: rtl/serial_comp_sched.sv
// serial_comp_sched
//  Round-robin scheduler sharing one bit-serial 2's-complement engine among
//  N requesters. One operation is in flight at a time:
//   IDLE -> CLR -> LOAD -> SHIFT (W cycles) -> CAP -> RESP -> IDLE
//  Ports:
//   clk  clock
//   rst  asynchronous active-low reset
//   bus  serial_comp_sched_if.slave (requests, engine controls, result handshake)
//  All outputs are registers and take their new value together with the state
//  they belong to, except res_valid, which rises on the second RESP cycle.
module serial_comp_sched #(
    parameter int W = 4,
    parameter int N = 4
) (
    input  logic clk,
    input  logic rst,
    serial_comp_sched_if.slave bus
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(W + 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CLR   = 3'd1;
    localparam logic [2:0] ST_LOAD  = 3'd2;
    localparam logic [2:0] ST_SHIFT = 3'd3;
    localparam logic [2:0] ST_CAP   = 3'd4;
    localparam logic [2:0] ST_RESP  = 3'd5;

    localparam logic [IW-1:0] LAST_ID  = IW'(N - 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(W - 1);

    // First set request at or after ptr, wrapping modulo N.
    function automatic logic [IW-1:0] rr_pick(input logic [N-1:0] r, input logic [IW-1:0] ptr);
        logic [IW-1:0] win;
        logic          found;
        int            idx;
        win   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && r[idx]) begin
                win   = IW'(idx);
                found = 1'b1;
            end
        end
        return win;
    endfunction

    logic [2:0]    state_r;
    logic [IW-1:0] ptr_r;
    logic [W-1:0]  op_r;
    logic [IW-1:0] id_r;
    logic [CW-1:0] cnt_r;
    logic [N-1:0]  gnt_r;
    logic          busy_r;
    logic          eng_rst_n_r;
    logic          eng_load_r;
    logic [W-1:0]  eng_num_r;
    logic          res_valid_r;
    logic [W-1:0]  res_data_r;
    logic [IW-1:0] res_id_r;

    logic          any_req_s;
    logic [IW-1:0] win_s;
    logic [N-1:0]  win_onehot_s;
    logic [IW-1:0] next_ptr_s;

    // Arbitration: winner, its one-hot grant and the pointer that follows it.
    always_comb begin
        any_req_s    = |bus.req;
        win_s        = rr_pick(bus.req, ptr_r);
        win_onehot_s = {{(N-1){1'b0}}, 1'b1} << win_s;
        if (win_s == LAST_ID) begin
            next_ptr_s = '0;
        end else begin
            next_ptr_s = win_s + IW'(1);
        end
    end

    // Operation sequencer and all registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            ptr_r       <= '0;
            op_r        <= '0;
            id_r        <= '0;
            cnt_r       <= '0;
            gnt_r       <= '0;
            busy_r      <= 1'b0;
            eng_rst_n_r <= 1'b0;
            eng_load_r  <= 1'b0;
            eng_num_r   <= '0;
            res_valid_r <= 1'b0;
            res_data_r  <= '0;
            res_id_r    <= '0;
        end else begin
            gnt_r <= '0;
            case (state_r)
                ST_IDLE: begin
                    eng_load_r <= 1'b0;
                    if (any_req_s) begin
                        gnt_r       <= win_onehot_s;
                        op_r        <= bus.req_data[win_s*W +: W];
                        id_r        <= win_s;
                        ptr_r       <= next_ptr_s;
                        busy_r      <= 1'b1;
                        // Clear pulse re-arms the engine carry before every load.
                        eng_rst_n_r <= 1'b0;
                        state_r     <= ST_CLR;
                    end else begin
                        busy_r      <= 1'b0;
                        eng_rst_n_r <= 1'b1;
                        state_r     <= ST_IDLE;
                    end
                end
                ST_CLR: begin
                    eng_rst_n_r <= 1'b1;
                    eng_load_r  <= 1'b1;
                    eng_num_r   <= op_r;
                    state_r     <= ST_LOAD;
                end
                ST_LOAD: begin
                    eng_load_r <= 1'b0;
                    cnt_r      <= '0;
                    state_r    <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    // The engine shifts on each of the W edges closing these cycles.
                    if (cnt_r == LAST_BIT) begin
                        state_r <= ST_CAP;
                    end else begin
                        cnt_r   <= cnt_r + CW'(1);
                        state_r <= ST_SHIFT;
                    end
                end
                ST_CAP: begin
                    res_data_r <= bus.eng_result;
                    res_id_r   <= id_r;
                    state_r    <= ST_RESP;
                end
                ST_RESP: begin
                    if (res_valid_r && bus.res_ready) begin
                        res_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        state_r     <= ST_IDLE;
                    end else begin
                        res_valid_r <= 1'b1;
                        state_r     <= ST_RESP;
                    end
                end
                default: begin
                    busy_r      <= 1'b0;
                    eng_rst_n_r <= 1'b1;
                    eng_load_r  <= 1'b0;
                    res_valid_r <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt       = gnt_r;
    assign bus.busy      = busy_r;
    assign bus.eng_rst_n = eng_rst_n_r;
    assign bus.eng_load  = eng_load_r;
    assign bus.eng_num   = eng_num_r;
    assign bus.res_valid = res_valid_r;
    assign bus.res_data  = res_data_r;
    assign bus.res_id    = res_id_r;
endmodule
